// File: rtl/hwpe_sm_pkg.sv
// hwpe_sm_pkg: shared types and constants for the shared-memory HWPE port sharer.
package hwpe_sm_pkg;
  localparam int unsigned ID_PORT_W       = 8;
  localparam logic        TCDM_TYPE_READ  = 1'b1;
  localparam logic        TCDM_TYPE_WRITE = 1'b0;
  typedef struct packed {
    logic [ID_PORT_W-1:0] port;
    logic                 is_read;
  } sharer_id_t;
endpackage

// File: rtl/hwpe_sm_id_fifo.sv
// hwpe_sm_id_fifo: synchronous FIFO holding the IDs of granted, unanswered transactions.
module hwpe_sm_id_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign cnt_d   = cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (clear_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= do_push ? wr_q + 1'b1 : wr_q;
      rd_q  <= do_pop ? rd_q + 1'b1 : rd_q;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/hwpe_sm_port_sharer.sv
// hwpe_sm_port_sharer: round-robin sharing of N accelerator memory ports onto one TCDM port,
// with in-order response routing through an ID FIFO.
module hwpe_sm_port_sharer
  import hwpe_sm_pkg::*;
#(
  parameter int unsigned N_PORTS         = 4,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned BE_WIDTH        = DATA_WIDTH/8,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 clear_i,
  input  logic [N_PORTS-1:0]                   acc_cs_n_i,
  input  logic [N_PORTS-1:0]                   acc_we_i,
  input  logic [N_PORTS-1:0][ADDR_WIDTH-1:0]   acc_addr_i,
  input  logic [N_PORTS-1:0][BE_WIDTH-1:0]     acc_be_i,
  input  logic [N_PORTS-1:0][DATA_WIDTH-1:0]   acc_wdata_i,
  output logic [N_PORTS-1:0]                   acc_wait_n_o,
  output logic [N_PORTS-1:0]                   acc_rvalid_o,
  output logic [N_PORTS-1:0][DATA_WIDTH-1:0]   acc_rdata_o,
  output logic                                 tcdm_req_o,
  input  logic                                 tcdm_gnt_i,
  output logic [ADDR_WIDTH-1:0]                tcdm_add_o,
  output logic                                 tcdm_type_o,
  output logic [BE_WIDTH-1:0]                  tcdm_be_o,
  output logic [DATA_WIDTH-1:0]                tcdm_data_o,
  input  logic [DATA_WIDTH-1:0]                tcdm_r_data_i,
  input  logic                                 tcdm_r_valid_i,
  output logic                                 busy_o,
  output logic                                 err_o
);
  localparam int unsigned PW = N_PORTS > 1 ? $clog2(N_PORTS) : 1;
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING) + 1;
  logic [PW-1:0] rr_q, rr_d, win;
  logic any, accept, full, empty, pop, err_q, err_d;
  logic [CW-1:0] count;
  sharer_id_t push_id, head;
  always_comb begin
    logic [PW-1:0] c;
    c   = '0;
    win = '0;
    any = 1'b0;
    for (int k = 0; k < N_PORTS; k++) begin
      c = PW'((32'(rr_q) + 32'(k)) % N_PORTS);
      if (!any && !acc_cs_n_i[c]) begin
        win = c;
        any = 1'b1;
      end
    end
  end
  // req depends only on registered occupancy, never on r_valid
  assign tcdm_req_o  = any && !full;
  assign accept      = tcdm_req_o && tcdm_gnt_i;
  assign tcdm_add_o  = any ? acc_addr_i[win] : '0;
  assign tcdm_be_o   = any ? acc_be_i[win] : '0;
  assign tcdm_data_o = any ? acc_wdata_i[win] : '0;
  assign tcdm_type_o = any ? (acc_we_i[win] ? TCDM_TYPE_WRITE : TCDM_TYPE_READ) : 1'b0;
  assign pop         = tcdm_r_valid_i && !empty;
  assign err_d       = err_q | (tcdm_r_valid_i & empty);
  assign rr_d        = accept ? (win == PW'(N_PORTS - 1) ? '0 : win + 1'b1) : rr_q;
  assign push_id     = '{port: ID_PORT_W'(win), is_read: !acc_we_i[win]};
  assign busy_o      = count != '0;
  assign err_o       = err_q;
  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      acc_wait_n_o[i] = accept && win == PW'(i);
      acc_rvalid_o[i] = pop && head.is_read && head.port == ID_PORT_W'(i);
      acc_rdata_o[i]  = (pop && head.is_read && head.port == ID_PORT_W'(i)) ? tcdm_r_data_i : '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q  <= '0;
      err_q <= 1'b0;
    end else if (clear_i) begin
      rr_q  <= '0;
      err_q <= 1'b0;
    end else begin
      rr_q  <= rr_d;
      err_q <= err_d;
    end
  end
  hwpe_sm_id_fifo #(
    .WIDTH ($bits(sharer_id_t)),
    .DEPTH (MAX_OUTSTANDING)
  ) i_id_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (clear_i),
    .push_i  (accept),
    .data_i  (push_id),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );
endmodule
